dmem_ctrl: RTL and testbench

Data-memory access controller for the MIPS core: sits directly downstream of the datapath's `aluout`/`writedata` outputs and upstream of its `readdata` input. It converts single-cycle load/store requests into a req/ack handshake on an external memory bus. It holds the core with `stall` until the access completes, and flags misaligned or timed-out accesses on `fault`.

---
 rtl/dmem_ctrl_pkg.sv | 22 ++
 rtl/dmem_timeout.sv | 44 ++++
 rtl/dmem_ctrl.sv | 136 +++++++++++++
 tb/tb_dmem_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared definitions for the data-memory access controller.
//   state_t          : controller FSM state encoding (IDLE / BUSY / DONE)
//   DMEM_FAULT_DATA  : value returned on readdata for a faulting access
//   is_aligned()     : word-alignment test on the two address LSBs
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_FAULT_DATA = 32'h0;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_timeout.sv
// -----------------------------------------------------------------------------
// dmem_timeout
// BUSY-cycle watchdog for dmem_ctrl. Only compiled when DMEM_CTRL_TIMEOUT_EN
// is defined; the default build contains no counter at all.
// Ports:
//   clk, reset_n : core clock, asynchronous active-low reset
//   clear        : high for the cycle that enters BUSY; zeroes the count
//   busy         : controller is in BUSY
//   ack          : bus_ack from memory (an acked cycle does not count)
//   expired      : this BUSY cycle is the TIMEOUT_CYCLES-th without an ack
// -----------------------------------------------------------------------------
`ifdef DMEM_CTRL_TIMEOUT_EN
module dmem_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (busy && !ack) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Firing one cycle early (count == limit-1) means the count reaches the
  // limit on the same edge the controller leaves BUSY, so bus_req is high for
  // exactly TIMEOUT_CYCLES cycles.
  assign expired = busy && !ack && (count_q == LAST_COUNT);

endmodule
`endif

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory access controller for the MIPS core. Turns a single-cycle
// load/store request into a req/ack bus transaction and stalls the core until
// it completes. Misaligned (and, optionally, timed-out) accesses pulse fault.
// Optional feature macro: DMEM_CTRL_TIMEOUT_EN (adds the dmem_timeout watchdog).
// Ports:
//   clk, reset_n        : core clock, asynchronous active-low reset
//   memread, memwrite   : load / store request (store wins if both high)
//   addr, wdata         : byte address and store data from the datapath
//   readdata            : load result (held between accesses)
//   stall               : hold PC / suppress regwrite
//   fault               : one-cycle pulse on completion of a faulting access
//   bus_req/we/addr/wdata : memory bus request, driven only in BUSY
//   bus_ack, bus_rdata  : memory completion and read data (same cycle)
// -----------------------------------------------------------------------------
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        we_q, fault_q;
  logic        req, aligned, busy, expired;

  assign req     = memread | memwrite;
  assign aligned = is_aligned(addr[1:0]);
  assign busy    = (state_q == ST_BUSY);

`ifdef DMEM_CTRL_TIMEOUT_EN
  logic start_busy;
  assign start_busy = (state_q == ST_IDLE) && req && aligned;

  dmem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_busy),
    .busy    (busy),
    .ack     (bus_ack),
    .expired (expired)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  // Next state and stall.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall = req;
        if (req) state_d = aligned ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (bus_ack || expired) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decode straight from the state register so that an
  // asynchronous reset drops bus_req immediately.
  assign bus_req   = busy;
  assign bus_we    = busy & we_q;
  assign bus_addr  = busy ? addr_q  : '0;
  assign bus_wdata = busy ? wdata_q : '0;
  assign readdata  = rdata_q;
  assign fault     = (state_q == ST_DONE) & fault_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (aligned) begin
              addr_q  <= addr;
              wdata_q <= wdata;
              we_q    <= memwrite;
            end else begin
              fault_q <= 1'b1;
              rdata_q <= DMEM_FAULT_DATA;
            end
          end
        end
        ST_BUSY: begin
          // Ack takes priority over a coincident timeout.
          if (bus_ack) begin
            rdata_q <= we_q ? '0 : bus_rdata;
          end else if (expired) begin
            fault_q <= 1'b1;
            rdata_q <= DMEM_FAULT_DATA;
          end
        end
        ST_DONE: fault_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl. A transaction-level model derives the
// expected per-cycle outputs of each access (IDLE, N+1 BUSY cycles, DONE) and
// a negedge compare process checks every output each cycle. Directed literal
// checks pin stall/request counts, request spacing and returned data.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0, bus_ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic [31:0] readdata, bus_addr, bus_wdata;
  logic        stall, fault, bus_req, bus_we;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .readdata  (readdata),
    .stall     (stall),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the model.
  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_fault = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rd = '0;
  logic        is_done = 1'b0;
  logic [31:0] m_last_rd = '0;

  // Observation counters for the literal pins.
  int          stall_cnt = 0, req_cnt = 0, fault_cnt = 0;
  int          cyc = 0, last_rise = 0, rise_gap = 0;
  logic        prev_req = 1'b0;
  logic [31:0] done_rd = '0;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("stall",     stall,     e_stall);
      check("fault",     fault,     e_fault);
      check("bus_req",   bus_req,   e_req);
      check("bus_we",    bus_we,    e_we);
      check("bus_addr",  bus_addr,  e_addr);
      check("bus_wdata", bus_wdata, e_wdata);
      check("readdata",  readdata,  e_rd);
    end
    if (stall)   stall_cnt++;
    if (bus_req) req_cnt++;
    if (fault)   fault_cnt++;
    if (bus_req && !prev_req) begin
      rise_gap  = cyc - last_rise;
      last_rise = cyc;
    end
    prev_req = bus_req;
    if (is_done) done_rd = readdata;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp(input logic s);
    e_stall = s; e_fault = 1'b0; e_req = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd = m_last_rd;
  endtask

  // One memory instruction. Called at posedge+1. waits = wait states before
  // ack; no_ack = memory never answers (only meaningful with timeout enabled).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic no_ack,
                        input logic [31:0] rdata, input logic idle_after);
    logic        misal, flt;
    int          nbusy;
    logic [31:0] res;
    misal = (a[1:0] != 2'b00);
    nbusy = no_ack ? TO : waits + 1;
    flt   = misal || no_ack;
    res   = (wr || flt) ? 32'h0 : rdata;
    stall_cnt = 0; req_cnt = 0; fault_cnt = 0;

    memread = rd; memwrite = wr; addr = a; wdata = wd; bus_ack = 1'b0;
    set_idle_exp(rd | wr);
    next_cycle();

    if (!misal) begin
      for (int k = 0; k < nbusy; k++) begin
        bus_ack   = !no_ack && (k == waits);
        bus_rdata = bus_ack ? rdata : 32'hDEAD_BEEF;
        e_stall = 1'b1; e_fault = 1'b0; e_req = 1'b1; e_we = wr;
        e_addr = a; e_wdata = wd; e_rd = m_last_rd;
        next_cycle();
      end
    end

    bus_ack = 1'b0;
    m_last_rd = res;
    e_stall = 1'b0; e_fault = flt; e_req = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd = res;
    is_done = 1'b1;
    next_cycle();
    is_done = 1'b0;

    if (idle_after) begin
      // An ack with no request outstanding must be ignored.
      memread = 1'b0; memwrite = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
      set_idle_exp(1'b0);
      next_cycle();
      bus_ack = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked while reset is held.
    #2;
    check("rst_bus_req",   bus_req,   1'b0);
    check("rst_bus_we",    bus_we,    1'b0);
    check("rst_bus_addr",  bus_addr,  32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_readdata",  readdata,  32'h0);
    check("rst_fault",     fault,     1'b0);
    check("rst_stall_lo",  stall,     1'b0);
    memread = 1'b1;
    #1;
    check("rst_stall_hi",  stall,     1'b1);
    memread = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    set_idle_exp(1'b0);
    chk_en = 1'b1;
    next_cycle();

    // Zero-wait load.
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b1);
    check("t1_stall_cycles", stall_cnt, 2);
    check("t1_req_cycles",   req_cnt,   1);
    check("t1_done_rd",      done_rd,   32'h1234_5678);
    check("t1_faults",       fault_cnt, 0);

    // Store with three wait states.
    access(1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 3, 1'b0, 32'h5555_AAAA, 1'b1);
    check("t2_req_cycles",   req_cnt,   4);
    check("t2_stall_cycles", stall_cnt, 5);
    check("t2_done_rd",      done_rd,   32'h0);

    // Misaligned load.
    access(1'b1, 1'b0, 32'h42, 32'h0, 0, 1'b0, 32'h9999_9999, 1'b1);
    check("t3_req_cycles",   req_cnt,   0);
    check("t3_faults",       fault_cnt, 1);
    check("t3_done_rd",      done_rd,   32'h0);

    // memread and memwrite together: the store wins.
    access(1'b1, 1'b1, 32'h48, 32'h0102_0304, 1, 1'b0, 32'h7777_7777, 1'b1);
    check("t4_req_cycles",   req_cnt,   2);
    check("t4_done_rd",      done_rd,   32'h0);

    // Load with two wait states.
    access(1'b1, 1'b0, 32'h4C, 32'h0, 2, 1'b0, 32'hA5A5_5A5A, 1'b1);
    check("t5_req_cycles",   req_cnt,   3);
    check("t5_done_rd",      done_rd,   32'hA5A5_5A5A);

`ifdef DMEM_CTRL_TIMEOUT_EN
    // Memory never acks: abort after TO busy cycles with a fault.
    access(1'b1, 1'b0, 32'h50, 32'h0, 0, 1'b1, 32'h1111_1111, 1'b1);
    check("t6_req_cycles",   req_cnt,   4);
    check("t6_faults",       fault_cnt, 1);
    check("t6_done_rd",      done_rd,   32'h0);
    // Ack in the very cycle the timeout would fire: ack wins.
    access(1'b1, 1'b0, 32'h54, 32'h0, TO - 1, 1'b0, 32'h0000_0077, 1'b1);
    check("t7_req_cycles",   req_cnt,   4);
    check("t7_faults",       fault_cnt, 0);
    check("t7_done_rd",      done_rd,   32'h0000_0077);
`else
    // Without the watchdog a long wait simply completes.
    access(1'b1, 1'b0, 32'h50, 32'h0, 6, 1'b0, 32'h1111_1111, 1'b1);
    check("t6_req_cycles",   req_cnt,   7);
    check("t6_faults",       fault_cnt, 0);
    check("t6_done_rd",      done_rd,   32'h1111_1111);
`endif

    // Reset asserted mid-access.
    memread = 1'b1; addr = 32'h60; wdata = 32'h0; bus_ack = 1'b0;
    set_idle_exp(1'b1);
    next_cycle();
    e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h60; e_wdata = 32'h0;
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmid_bus_req",  bus_req,  1'b0);
    check("rstmid_bus_addr", bus_addr, 32'h0);
    check("rstmid_readdata", readdata, 32'h0);
    memread = 1'b0;
    #1;
    check("rstmid_stall",    stall,    1'b0);
    m_last_rd = 32'h0;
    next_cycle();
    reset_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    set_idle_exp(1'b0);
    chk_en = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    next_cycle();

    // Back-to-back zero-wait loads.
    access(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h1010_1010, 1'b0);
    check("t8_first_rd",     done_rd,   32'h1010_1010);
    access(1'b1, 1'b0, 32'h14, 32'h0, 0, 1'b0, 32'h1414_1414, 1'b1);
    check("t8_second_rd",    done_rd,   32'h1414_1414);
    check("t8_req_spacing",  rise_gap,  3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
